// File: rtl/ram_pkg.sv
// Shared encodings for the RAM arbiter: FSM states, requester IDs, RAM op codes.
package ram_pkg;

    typedef enum logic {
        BOOT   = 1'b0,
        SHARED = 1'b1
    } arb_state_e;

    localparam logic REQ_A     = 1'b0;
    localparam logic REQ_B     = 1'b1;

    localparam logic RAM_WRITE = 1'b1;
    localparam logic RAM_READ  = 1'b0;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. On contention the requester not granted last wins.
// mask_b blocks requester B entirely (used while A owns memory during boot).
module rr_arb2
    import ram_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic mask_b,
    output logic gnt_a,
    output logic gnt_b
);

    logic last_q;
    logic last_d;
    logic eff_b;

    // Grant decode; grants are held low while reset is asserted.
    always_comb begin
        gnt_a  = 1'b0;
        gnt_b  = 1'b0;
        last_d = last_q;
        eff_b  = req_b & ~mask_b;
        if (rst_n) begin
            if (req_a && eff_b) begin
                gnt_a = (last_q == REQ_B);
                gnt_b = (last_q == REQ_A);
            end else begin
                gnt_a = req_a;
                gnt_b = eff_b;
            end
        end
        if (gnt_a) begin
            last_d = REQ_A;
        end else if (gnt_b) begin
            last_d = REQ_B;
        end
    end

    // Last-granted register; resets to B so A wins the first contested cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= REQ_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: boot-phase exclusive access for the core (A), then
// round-robin sharing with the read-only judge port (B). Read data is registered.
module ram_arbiter
    import ram_pkg::*;
#(
    parameter int unsigned W  = 32,
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [W-1:0]  a_wdata,
    input  logic          a_boot_done,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [W-1:0]  a_rdata,
    input  logic          b_req,
    input  logic [AW-1:0] b_addr,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [W-1:0]  b_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [W-1:0]  ram_data_in,
    output logic          ram_rw,
    output logic          ram_oe,
    input  logic [W-1:0]  ram_data_out
);

    arb_state_e state_q;
    arb_state_e state_d;

    logic          a_rvalid_q;
    logic          b_rvalid_q;
    logic [W-1:0]  a_rdata_q;
    logic [W-1:0]  b_rdata_q;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_a  (a_req),
        .req_b  (b_req),
        .mask_b (state_q == BOOT),
        .gnt_a  (a_gnt),
        .gnt_b  (b_gnt)
    );

    // Boot-to-shared transition; one-way until reset.
    always_comb begin
        state_d = state_q;
        if (state_q == BOOT && a_boot_done) begin
            state_d = SHARED;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // RAM drive mux; idle bus is all zeros.
    always_comb begin
        ram_addr    = '0;
        ram_data_in = '0;
        ram_rw      = RAM_READ;
        ram_oe      = 1'b0;
        if (a_gnt) begin
            ram_addr = a_addr;
            if (a_we) begin
                ram_rw      = RAM_WRITE;
                ram_data_in = a_wdata;
            end else begin
                ram_oe = 1'b1;
            end
        end else if (b_gnt) begin
            ram_addr = b_addr;
            ram_oe   = 1'b1;
        end
    end

    // Read return: capture RAM output into the winner's rdata and pulse its rvalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            a_rvalid_q <= a_gnt & ~a_we;
            b_rvalid_q <= b_gnt;
            if (a_gnt && !a_we) begin
                a_rdata_q <= ram_data_out;
            end
            if (b_gnt) begin
                b_rdata_q <= ram_data_out;
            end
        end
    end

    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a small behavioural RAM.
module tb_ram_arbiter;

    localparam int unsigned W  = 32;
    localparam int unsigned AW = 3;

    logic          clk;
    logic          rst_n;
    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [W-1:0]  a_wdata;
    logic          a_boot_done;
    logic          a_gnt;
    logic          a_rvalid;
    logic [W-1:0]  a_rdata;
    logic          b_req;
    logic [AW-1:0] b_addr;
    logic          b_gnt;
    logic          b_rvalid;
    logic [W-1:0]  b_rdata;
    logic [AW-1:0] ram_addr;
    logic [W-1:0]  ram_data_in;
    logic          ram_rw;
    logic          ram_oe;
    logic [W-1:0]  ram_data_out;

    logic [W-1:0]  mem [8];

    int n_tests;
    int n_fail;

    ram_arbiter #(
        .W  (W),
        .AW (AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a_req        (a_req),
        .a_we         (a_we),
        .a_addr       (a_addr),
        .a_wdata      (a_wdata),
        .a_boot_done  (a_boot_done),
        .a_gnt        (a_gnt),
        .a_rvalid     (a_rvalid),
        .a_rdata      (a_rdata),
        .b_req        (b_req),
        .b_addr       (b_addr),
        .b_gnt        (b_gnt),
        .b_rvalid     (b_rvalid),
        .b_rdata      (b_rdata),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_rw       (ram_rw),
        .ram_oe       (ram_oe),
        .ram_data_out (ram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: synchronous write, combinational read.
    always @(posedge clk) begin
        if (ram_rw) mem[ram_addr] <= ram_data_in;
    end
    assign ram_data_out = mem[ram_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] boot_vals [4];
        boot_vals = '{32'd33, 32'd58, 32'd47, 32'd159};
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 8; i++) mem[i] = '0;

        // Reset: grants forced low even with a request present.
        rst_n = 1'b0; a_req = 1'b1; a_we = 1'b1; a_addr = '0; a_wdata = 32'hdead_beef;
        a_boot_done = 1'b0; b_req = 1'b0; b_addr = '0;
        #2;
        check_eq("rst_a_gnt", 32'(a_gnt), 0);
        check_eq("rst_ram_rw", 32'(ram_rw), 0);
        check_eq("rst_a_rvalid", 32'(a_rvalid), 0);
        check_eq("rst_b_rvalid", 32'(b_rvalid), 0);
        check_eq("rst_a_rdata", a_rdata, 0);
        check_eq("rst_b_rdata", b_rdata, 0);
        a_req = 1'b0;
        step();
        #2 rst_n = 1'b1;
        step();

        // Boot load with B waiting on addr 2; boot_done overlaps the last write.
        b_req = 1'b1; b_addr = 3'd2;
        for (int i = 0; i < 4; i++) begin
            a_req = 1'b1; a_we = 1'b1; a_addr = AW'(i); a_wdata = boot_vals[i];
            a_boot_done = (i == 3);
            #1;
            check_eq($sformatf("boot%0d_a_gnt", i), 32'(a_gnt), 1);
            check_eq($sformatf("boot%0d_b_gnt", i), 32'(b_gnt), 0);
            check_eq($sformatf("boot%0d_ram_rw", i), 32'(ram_rw), 1);
            check_eq($sformatf("boot%0d_ram_addr", i), 32'(ram_addr), i);
            check_eq($sformatf("boot%0d_ram_din", i), ram_data_in, boot_vals[i]);
            step();
            check_eq($sformatf("boot%0d_a_rvalid", i), 32'(a_rvalid), 0);
            check_eq($sformatf("boot%0d_b_rvalid", i), 32'(b_rvalid), 0);
        end
        a_req = 1'b0; a_we = 1'b0; a_boot_done = 1'b0;
        #1;
        check_eq("post_boot_b_gnt", 32'(b_gnt), 1);
        check_eq("post_boot_ram_oe", 32'(ram_oe), 1);
        check_eq("post_boot_ram_addr", 32'(ram_addr), 2);
        step();
        b_req = 1'b0;
        check_eq("post_boot_b_rvalid", 32'(b_rvalid), 1);
        check_eq("post_boot_b_rdata", b_rdata, 47);
        #1;
        check_eq("idle_ram_oe", 32'(ram_oe), 0);
        check_eq("idle_ram_addr", 32'(ram_addr), 0);
        check_eq("idle_ram_din", ram_data_in, 0);
        step();
        check_eq("idle_b_rvalid", 32'(b_rvalid), 0);

        // Contention: last grant was B, so A, B, A, B.
        a_req = 1'b1; a_we = 1'b0; a_addr = 3'd0;
        b_req = 1'b1; b_addr = 3'd3;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq($sformatf("cont%0d_a_gnt", i), 32'(a_gnt), (i % 2 == 0) ? 1 : 0);
            check_eq($sformatf("cont%0d_b_gnt", i), 32'(b_gnt), (i % 2 == 1) ? 1 : 0);
            step();
            if (i % 2 == 0) begin
                check_eq($sformatf("cont%0d_a_rvalid", i), 32'(a_rvalid), 1);
                check_eq($sformatf("cont%0d_b_rvalid", i), 32'(b_rvalid), 0);
                check_eq($sformatf("cont%0d_a_rdata", i), a_rdata, 33);
            end else begin
                check_eq($sformatf("cont%0d_b_rvalid", i), 32'(b_rvalid), 1);
                check_eq($sformatf("cont%0d_a_rvalid", i), 32'(a_rvalid), 0);
                check_eq($sformatf("cont%0d_b_rdata", i), b_rdata, 159);
            end
        end
        b_req = 1'b0;

        // Write then read back at address 6.
        a_we = 1'b1; a_addr = 3'd6; a_wdata = 32'h0010_2283;
        #1;
        check_eq("wr6_a_gnt", 32'(a_gnt), 1);
        check_eq("wr6_ram_rw", 32'(ram_rw), 1);
        step();
        check_eq("wr6_a_rvalid", 32'(a_rvalid), 0);
        a_we = 1'b0;
        step();
        a_req = 1'b0;
        check_eq("rd6_a_rvalid", 32'(a_rvalid), 1);
        check_eq("rd6_a_rdata", a_rdata, 32'h0010_2283);
        check_eq("rd6_b_rvalid", 32'(b_rvalid), 0);
        check_eq("rd6_b_rdata_hold", b_rdata, 159);

        // boot_done while SHARED is ignored; B still served.
        a_boot_done = 1'b1; b_req = 1'b1; b_addr = 3'd1;
        #1;
        check_eq("shared_boot_b_gnt", 32'(b_gnt), 1);
        step();
        a_boot_done = 1'b0;
        check_eq("shared_boot_b_rdata", b_rdata, 58);

        // Async reset during a B read grant.
        b_addr = 3'd3;
        #1;
        check_eq("prerst_b_gnt", 32'(b_gnt), 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_b_gnt", 32'(b_gnt), 0);
        check_eq("midrst_ram_rw", 32'(ram_rw), 0);
        check_eq("midrst_ram_oe", 32'(ram_oe), 0);
        step();
        check_eq("midrst_b_rvalid", 32'(b_rvalid), 0);
        check_eq("midrst_b_rdata", b_rdata, 0);
        #3 rst_n = 1'b1;
        step();
        check_eq("postrst_b_gnt", 32'(b_gnt), 0);
        a_req = 1'b1; a_we = 1'b0; a_addr = 3'd1;
        #1;
        check_eq("postrst_a_gnt", 32'(a_gnt), 1);
        check_eq("postrst_b_gnt_contested", 32'(b_gnt), 0);
        step();
        a_req = 1'b0;
        check_eq("postrst_a_rdata", a_rdata, 58);
        check_eq("postrst_b_rvalid", 32'(b_rvalid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Single-port RAM arbiter sharing the `ram` block between the program core (requester A, read/write) and the judge readback port (requester B, read-only). After reset, A owns the memory exclusively until it signals boot completion. The arbiter then grants one transaction per cycle by round-robin. It replaces the ad-hoc `rw`-driven address mux in front of the RAM and returns registered read data with valid strobes.

## Interface
- `W`, 32, data word width
- `AW`, 3, RAM address width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `a_req`  in  1  A requests a transaction this cycle
- `a_we`  in  1  A transaction is a write (1) or read (0)
- `a_addr`  in  AW  A address
- `a_wdata`  in  W  A write data
- `a_boot_done`  in  1  one-cycle pulse: A has finished loading memory
- `a_gnt`  out  1  A transaction accepted this cycle (combinational)
- `a_rvalid`  out  1  A read data valid
- `a_rdata`  out  W  A read data
- `b_req`  in  1  B read request
- `b_addr`  in  AW  B address
- `b_gnt`  out  1  B request accepted this cycle (combinational)
- `b_rvalid`  out  1  B read data valid
- `b_rdata`  out  W  B read data
- `ram_addr`  out  AW  to RAM `addr`
- `ram_data_in`  out  W  to RAM `data_in`
- `ram_rw`  out  1  to RAM `rw`; 1 = write, 0 = read
- `ram_oe`  out  1  to RAM `oe`
- `ram_data_out`  in  W  from RAM `data_out`; combinational read

## Operation
- States: `BOOT` (reset state) and `SHARED`. `BOOT` → `SHARED` on `a_boot_done` at a clock edge. There is no return path except reset.
- `BOOT`: `a_gnt = a_req`. `b_gnt = 0`. B requests stall, and B must hold `b_req`/`b_addr` stable until granted.
- `SHARED`, single requester: that requester is granted.
- `SHARED`, both requesting: the requester not granted last wins. The `last` register updates on every grant.
- `last` resets to B, so A wins the first contested cycle.
- At most one grant per cycle. A requester holds `req` and payload stable until `gnt`.
- Granted write: `ram_rw=1`, `ram_addr=a_addr`, `ram_data_in=a_wdata`, `ram_oe=0`.
- Granted read: `ram_rw=0`, `ram_addr` is the winner's address, `ram_oe=1`. `ram_data_out` is captured at the clock edge into the winner's `rdata`. The winner's `rvalid` pulses for one cycle after that edge.
- No grant: `ram_rw=0`, `ram_oe=0`, `ram_addr=0`, `ram_data_in=0`.
- `rdata` holds its last value until the next read for that requester. A writes produce no `rvalid`.
- `a_boot_done` in the same cycle as an A grant: the A transaction completes normally, and B may win from the next cycle.
- `a_boot_done` while already in `SHARED`: ignored.

## Timing
- Grant latency is 0 cycles; grant and RAM drive are combinational from `req`, state and `last`.
- Read latency is 1 cycle: `rvalid`/`rdata` are registered from the edge ending the grant cycle.
- Back-to-back grants to the same requester are allowed every cycle when uncontested.
- Contested throughput alternates A, B, A, B, …
- Reset values: state `BOOT`, `last` = B, `a_rvalid=0`, `b_rvalid=0`, `a_rdata=0`, `b_rdata=0`.
- While `rst_n=0`, `a_gnt`, `b_gnt` and `ram_rw` are forced to 0.
- Reset asserted mid-transaction: pending `rvalid` is cleared immediately and the read is lost. The requester reissues after reset.

## Structure
- Shared package `ram_pkg`:
  - state encoding `BOOT=1'b0`, `SHARED=1'b1`
  - requester ID constants `REQ_A=1'b0`, `REQ_B=1'b1`
  - `RAM_WRITE=1'b1`, `RAM_READ=1'b0`
- One sub-module, `rr_arb2`: a 2-way round-robin grant with a `last` register, a `mask_b` input for `BOOT`, and asynchronous reset.
- The top level holds the FSM, RAM drive mux and read-return registers.
- The `ram` instance stays outside this block.

## Test plan
- Boot load: `a_req`/`a_we=1` writes 33, 58, 47, 159 to addresses 0–3, with `b_req=1` addr 2 held throughout. Required: `b_gnt=0` until `a_boot_done`, then `b_gnt` next cycle, `b_rvalid` one cycle later with `b_rdata=47`.
- Contention: in `SHARED`, both request reads every cycle (A addr 0, B addr 3). Required: grants A, B, A, B starting with A, and `rdata` 33/159 with `rvalid` one cycle after each grant.
- Write-then-read: A writes 0x00102283 to address 6, then reads address 6 the next cycle. Required: `a_rvalid=1`, `a_rdata=0x00102283`, and `b_rvalid` unaffected.
- Boot-edge overlap: `a_boot_done` pulses in the same cycle as an A write. Required: the write lands, and a waiting B is granted on the next cycle.
- Async reset: assert `rst_n=0` between clock edges during a B read grant. Required: `b_gnt=0` and `ram_rw=0` immediately, `b_rvalid` stays 0, and after release the state is `BOOT` again (B blocked).
